// File: rtl/fan_sched_pkg.sv
// Shared types and helpers for the fan duty scheduler.
package fan_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KICK  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } fan_state_t;

    localparam logic [6:0] DUTY_MAX = 7'd100;

    function automatic logic [6:0] clamp_duty(input logic [6:0] duty);
        logic [6:0] res;
        if (duty > DUTY_MAX) begin
            res = DUTY_MAX;
        end else begin
            res = duty;
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_CYC clocks.
module tick_gen #(
    parameter int TICK_CYC = 500_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYC - 1);

    logic [CNT_W-1:0] cnt_r;

    // Wrap counter; the tick is a decode of the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/fan_duty_sched.sv
// Fan duty scheduler: auto/manual arbitration, kick-start, slew ramp and stall retry.
module fan_duty_sched
    import fan_sched_pkg::*;
#(
    parameter int TICK_CYC       = 500_000,
    parameter int KICK_TICKS     = 50,
    parameter int STALL_TICKS    = 200,
    parameter int STALL_MIN_DUTY = 20,
    parameter int RETRY_MAX      = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cmd_valid,
    input  logic        cmd_manual,
    input  logic [6:0]  cmd_duty,
    input  logic [6:0]  auto_duty,
    input  logic [15:0] rpm,
    input  logic        fault_clr,
    output logic [6:0]  duty_data,
    output logic [1:0]  state,
    output logic        fault
);
    localparam int KICK_W  = $clog2(KICK_TICKS + 1);
    localparam int STALL_W = $clog2(STALL_TICKS + 1);
    localparam int RETRY_W = $clog2(RETRY_MAX + 1);

    fan_state_t         state_r;
    logic [6:0]         duty_r;
    logic               fault_r;
    logic [6:0]         cur_r;
    logic               mode_man_r;
    logic [6:0]         man_duty_r;
    logic [KICK_W-1:0]  kick_cnt_r;
    logic [STALL_W-1:0] stall_cnt_r;
    logic [RETRY_W-1:0] retry_cnt_r;
    logic               tick_s;
    logic [6:0]         target_s;
    logic [6:0]         ramp_s;

    tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .tick (tick_s)
    );

    // Command registers load in every state, including FAULT.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_man_r <= 1'b0;
            man_duty_r <= 7'd0;
        end else if (cmd_valid) begin
            mode_man_r <= cmd_manual;
            man_duty_r <= clamp_duty(cmd_duty);
        end else begin
            mode_man_r <= mode_man_r;
            man_duty_r <= man_duty_r;
        end
    end

    // Target arbitration and the one-step-per-tick slew toward it.
    always_comb begin
        target_s = mode_man_r ? man_duty_r : clamp_duty(auto_duty);
        ramp_s   = cur_r;
        if (tick_s && (cur_r < target_s)) begin
            ramp_s = cur_r + 7'd1;
        end else if (tick_s && (cur_r > target_s)) begin
            ramp_s = cur_r - 7'd1;
        end else begin
            ramp_s = cur_r;
        end
    end

    // Main FSM; duty_data and fault are registered alongside the next state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r     <= ST_IDLE;
            duty_r      <= 7'd0;
            fault_r     <= 1'b0;
            cur_r       <= 7'd0;
            kick_cnt_r  <= {KICK_W{1'b0}};
            stall_cnt_r <= {STALL_W{1'b0}};
            retry_cnt_r <= {RETRY_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    duty_r      <= 7'd0;
                    fault_r     <= 1'b0;
                    stall_cnt_r <= {STALL_W{1'b0}};
                    if (target_s != 7'd0) begin
                        state_r    <= ST_KICK;
                        kick_cnt_r <= {KICK_W{1'b0}};
                        duty_r     <= DUTY_MAX;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_KICK: begin
                    duty_r  <= DUTY_MAX;
                    fault_r <= 1'b0;
                    if (tick_s && (kick_cnt_r >= KICK_W'(KICK_TICKS - 1))) begin
                        state_r     <= ST_RUN;
                        kick_cnt_r  <= KICK_W'(KICK_TICKS);
                        cur_r       <= target_s;
                        duty_r      <= target_s;
                        stall_cnt_r <= {STALL_W{1'b0}};
                    end else if (tick_s) begin
                        kick_cnt_r <= kick_cnt_r + KICK_W'(1);
                    end else begin
                        kick_cnt_r <= kick_cnt_r;
                    end
                end
                ST_RUN: begin
                    cur_r   <= ramp_s;
                    duty_r  <= ramp_s;
                    fault_r <= 1'b0;
                    if ((cur_r == 7'd0) && (target_s == 7'd0)) begin
                        state_r     <= ST_IDLE;
                        duty_r      <= 7'd0;
                        retry_cnt_r <= {RETRY_W{1'b0}};
                        stall_cnt_r <= {STALL_W{1'b0}};
                    end else if (rpm != 16'd0) begin
                        // A spinning fan wins over a coincident stall terminal count.
                        stall_cnt_r <= {STALL_W{1'b0}};
                        retry_cnt_r <= {RETRY_W{1'b0}};
                    end else if (cur_r < 7'(STALL_MIN_DUTY)) begin
                        stall_cnt_r <= {STALL_W{1'b0}};
                    end else if (stall_cnt_r == STALL_W'(STALL_TICKS)) begin
                        stall_cnt_r <= {STALL_W{1'b0}};
                        if (retry_cnt_r < RETRY_W'(RETRY_MAX)) begin
                            retry_cnt_r <= retry_cnt_r + RETRY_W'(1);
                            state_r     <= ST_KICK;
                            kick_cnt_r  <= {KICK_W{1'b0}};
                            duty_r      <= DUTY_MAX;
                        end else begin
                            state_r <= ST_FAULT;
                            fault_r <= 1'b1;
                            duty_r  <= 7'd0;
                        end
                    end else if (tick_s) begin
                        stall_cnt_r <= stall_cnt_r + STALL_W'(1);
                    end else begin
                        stall_cnt_r <= stall_cnt_r;
                    end
                end
                ST_FAULT: begin
                    duty_r <= 7'd0;
                    if (fault_clr) begin
                        state_r     <= ST_IDLE;
                        fault_r     <= 1'b0;
                        retry_cnt_r <= {RETRY_W{1'b0}};
                    end else begin
                        state_r <= ST_FAULT;
                        fault_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    duty_r  <= 7'd0;
                    fault_r <= 1'b0;
                end
            endcase
        end
    end

    assign duty_data = duty_r;
    assign state     = state_r;
    assign fault     = fault_r;

endmodule

// File: tb/tb_fan_duty_sched.sv
// Directed scoreboard bench for fan_duty_sched with a fast tick.
module tb_fan_duty_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cmd_valid;
    logic        cmd_manual;
    logic [6:0]  cmd_duty;
    logic [6:0]  auto_duty;
    logic [15:0] rpm;
    logic        fault_clr;
    logic [6:0]  duty_data;
    logic [1:0]  state;
    logic        fault;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    logic [6:0] exp_q[$];

    fan_duty_sched #(
        .TICK_CYC(4), .KICK_TICKS(3), .STALL_TICKS(5),
        .STALL_MIN_DUTY(20), .RETRY_MAX(2)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid),
        .cmd_manual(cmd_manual), .cmd_duty(cmd_duty), .auto_duty(auto_duty),
        .rpm(rpm), .fault_clr(fault_clr), .duty_data(duty_data),
        .state(state), .fault(fault)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic cmd(input logic man, input logic [6:0] d);
        cmd_valid = 1'b1; cmd_manual = man; cmd_duty = d;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] st, input int budget);
        int c = 0;
        while ((state !== st) && (c < budget)) begin
            step(1);
            c++;
        end
        check(tag, 16'(state), 16'(st));
    endtask

    task automatic count_state(input logic [1:0] st, output int len);
        len = 0;
        while ((state === st) && (len < 100)) begin
            len++;
            step(1);
        end
    endtask

    task automatic drain(input string tag);
        logic [6:0] prev;
        logic [6:0] e;
        int c;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            prev = duty_data;
            c = 0;
            while ((duty_data === prev) && (c < 12)) begin
                step(1);
                c++;
            end
            check(tag, 16'(duty_data), 16'(e));
        end
    endtask

    initial begin
        int len;
        sys_rst = 1'b1; cmd_valid = 1'b0; cmd_manual = 1'b0; cmd_duty = 7'd0;
        auto_duty = 7'd0; rpm = 16'd0; fault_clr = 1'b0;
        step(3);
        check("reset_duty", 16'(duty_data), 16'd0);
        check("reset_state", 16'(state), 16'd0);
        check("reset_fault", 16'(fault), 16'd0);
        sys_rst = 1'b0;
        step(2);
        check("idle_zero_target", 16'(state), 16'd0);

        // Auto start at 40 %.
        auto_duty = 7'd40; rpm = 16'd1500;
        wait_state("auto_kick_state", 2'd1, 4);
        check("auto_kick_duty", 16'(duty_data), 16'd100);
        count_state(2'd1, len);
        check("kick_len_in_range", 16'(len >= 9 && len <= 12), 16'd1);
        check("auto_run_state", 16'(state), 16'd2);
        check("auto_run_duty", 16'(duty_data), 16'd40);

        // Manual ramp up by one per tick, then a clamped 120 command.
        cmd(1'b1, 7'd43);
        for (int v = 41; v <= 43; v++) exp_q.push_back(7'(v));
        drain("ramp_up_43");
        check("ramp_hold_run", 16'(state), 16'd2);
        cmd(1'b1, 7'd120);
        for (int v = 44; v <= 100; v++) exp_q.push_back(7'(v));
        drain("ramp_up_100");
        step(20);
        check("clamp_ceiling", 16'(duty_data), 16'd100);

        // Ramp down to 2 then to stop.
        cmd(1'b1, 7'd2);
        for (int v = 99; v >= 2; v--) exp_q.push_back(7'(v));
        drain("ramp_down_2");
        cmd(1'b1, 7'd0);
        exp_q.push_back(7'd1);
        exp_q.push_back(7'd0);
        drain("ramp_to_zero");
        wait_state("stop_idle_state", 2'd0, 6);
        check("stop_idle_duty", 16'(duty_data), 16'd0);

        // Stall: first retry, then a recovery, then two retries and a fault.
        rpm = 16'd0;
        cmd(1'b1, 7'd50);
        wait_state("stall_run1", 2'd2, 20);
        check("stall_run_duty", 16'(duty_data), 16'd50);
        count_state(2'd2, len);
        check("stall_run_len", 16'(len >= 20 && len <= 21), 16'd1);
        check("stall_retry1_kick", 16'(state), 16'd1);
        check("stall_retry1_duty", 16'(duty_data), 16'd100);
        wait_state("recov_run", 2'd2, 20);
        step(13);
        rpm = 16'd800;
        step(8);
        check("recov_no_retry", 16'(state), 16'd2);
        rpm = 16'd0;
        wait_state("retry_after_recov_a", 2'd1, 40);
        wait_state("retry_run_b", 2'd2, 20);
        wait_state("retry_after_recov_b", 2'd1, 40);
        wait_state("retry_run_c", 2'd2, 20);
        wait_state("fault_state", 2'd3, 40);
        check("fault_flag", 16'(fault), 16'd1);
        check("fault_duty", 16'(duty_data), 16'd0);
        cmd(1'b1, 7'd60);
        step(5);
        check("fault_holds_on_cmd", 16'(state), 16'd3);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        check("fault_clr_idle", 16'(state), 16'd0);
        check("fault_clr_flag", 16'(fault), 16'd0);
        step(1);
        check("fault_clr_kick", 16'(state), 16'd1);
        check("fault_clr_kick_duty", 16'(duty_data), 16'd100);

        // Asynchronous reset between clock edges while kicking.
        step(1);
        #2;
        sys_rst = 1'b1;
        #1;
        check("async_rst_duty", 16'(duty_data), 16'd0);
        check("async_rst_state", 16'(state), 16'd0);
        step(1);
        sys_rst = 1'b0;
        check("after_rst_fault", 16'(fault), 16'd0);

        if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
